ni_tx_injector: RTL and testbench

Network-interface transmit stage that feeds the LOCAL input port of a PE's Hermes router. The CPU side pushes payload flits into an internal buffer and issues a send command; the block then serialises a Hermes packet (header, size, payload) onto the router's local `rx`/`data_i`/`credit_o` link under credit-based flow control. One instance sits inside each `manycore_pe`, between the PE memory bus glue and the router LOCAL port.

---
 rtl/manycore_pkg.sv | 22 ++
 rtl/ni_fifo.sv | 62 ++++++
 rtl/ni_tx_injector.sv | 150 +++++++++++++++
 tb/tb_ni_tx_injector.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/manycore_pkg.sv
// Shared manycore types: flit type, NI transmit FSM states and XY address helpers.
package manycore_pkg;

  localparam int unsigned FLIT_WIDTH_DEF = 32;
  localparam int unsigned XY_X_SHIFT     = 8;

  typedef logic [FLIT_WIDTH_DEF-1:0] flit_t;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    SIZE,
    PAYLOAD,
    DONE
  } ni_tx_state_e;

  // Pack router coordinates into the 16-bit {X, Y} address used in header flits.
  function automatic logic [15:0] make_xy(input logic [7:0] x, input logic [7:0] y);
    return (16'(x) << XY_X_SHIFT) | 16'(y);
  endfunction

endpackage

// File: rtl/ni_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may happen in the same
// cycle, even when full. Head is read from registered storage (no fall-through).
module ni_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Accept a push when there is room or a pop frees a slot this cycle.
  always_comb begin
    push_ok  = push & (~full | pop);
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer and count registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ni_tx_injector.sv
// NI transmit stage: buffers payload flits and serialises header/size/payload
// onto the router LOCAL port under credit flow control.
// Optional statistics counters are enabled by defining NI_TX_STATS_EN.
module ni_tx_injector
  import manycore_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned BUF_DEPTH  = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [FLIT_WIDTH-1:0]       wr_data,
  input  logic                        start,
  input  logic [15:0]                 dest_xy,
  input  logic [LEN_WIDTH-1:0]        len,
  output logic                        tx,
  output logic [FLIT_WIDTH-1:0]       data_o,
  input  logic                        credit_i,
  output logic                        busy,
  output logic                        buf_full,
  output logic [$clog2(BUF_DEPTH):0]  buf_count,
  output logic                        overflow,
  output logic [31:0]                 pkt_sent,
  output logic [31:0]                 stall_cycles
);

  ni_tx_state_e           state_q, state_d;
  logic [15:0]            dest_q, dest_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic                   overflow_q, overflow_d;
  logic                   pop_c;
  logic                   fifo_empty;
  logic [FLIT_WIDTH-1:0]  fifo_head;

  ni_fifo #(
    .WIDTH (FLIT_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop_c),
    .head      (fifo_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (fifo_empty)
  );

  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

  // Next-state and link outputs; a flit moves when tx and credit_i are both high.
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    len_d      = len_q;
    rem_d      = rem_q;
    tx         = 1'b0;
    data_o     = '0;
    pop_c      = 1'b0;
    overflow_d = overflow_q | (wr_en & buf_full & ~pop_c);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HEADER;
          dest_d  = dest_xy;
          len_d   = len;
          rem_d   = len;
        end
      end
      HEADER: begin
        tx     = 1'b1;
        data_o = FLIT_WIDTH'(dest_q);
        if (credit_i) state_d = SIZE;
      end
      SIZE: begin
        tx     = 1'b1;
        data_o = FLIT_WIDTH'(len_q);
        if (credit_i) state_d = (len_q != '0) ? PAYLOAD : DONE;
      end
      PAYLOAD: begin
        tx     = ~fifo_empty;
        data_o = fifo_head;
        if (~fifo_empty && credit_i) begin
          pop_c = 1'b1;
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A pop frees a slot, so a simultaneous write into a full buffer is kept.
    overflow_d = overflow_q | (wr_en & buf_full & ~pop_c);
  end

  // Control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      dest_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef NI_TX_STATS_EN
  logic [31:0] pkt_q, pkt_d;
  logic [31:0] stall_q, stall_d;

  // Statistics: completed packets and cycles stalled on missing credit.
  always_comb begin
    pkt_d   = pkt_q + 32'(state_q == DONE);
    stall_d = stall_q + 32'(tx & ~credit_i);
  end

  // Statistics registers, wrapping modulo 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_q   <= '0;
      stall_q <= '0;
    end else begin
      pkt_q   <= pkt_d;
      stall_q <= stall_d;
    end
  end

  assign pkt_sent     = pkt_q;
  assign stall_cycles = stall_q;
`else
  assign pkt_sent     = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ni_tx_injector.sv
// Directed self-checking bench for ni_tx_injector.
module tb_ni_tx_injector;
  import manycore_pkg::*;

`ifdef NI_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  flit_t       wr_data;
  logic        start;
  logic [15:0] dest_xy;
  logic [15:0] len;
  logic        tx;
  flit_t       data_o;
  logic        credit_i;
  logic        busy;
  logic        buf_full;
  logic [4:0]  buf_count;
  logic        overflow;
  logic [31:0] pkt_sent;
  logic [31:0] stall_cycles;

  int checks = 0;
  int fails  = 0;

  ni_tx_injector dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .start        (start),
    .dest_xy      (dest_xy),
    .len          (len),
    .tx           (tx),
    .data_o       (data_o),
    .credit_i     (credit_i),
    .busy         (busy),
    .buf_full     (buf_full),
    .buf_count    (buf_count),
    .overflow     (overflow),
    .pkt_sent     (pkt_sent),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0;
    dest_xy = '0; len = '0; credit_i = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push(input flit_t v);
    wr_en = 1'b1; wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (tx !== 1'b0 || data_o !== 32'h0 || busy !== 1'b0 || buf_count !== 5'd0 ||
        buf_full !== 1'b0 || overflow !== 1'b0 || pkt_sent !== 32'd0 || stall_cycles !== 32'd0) begin
      fails++;
      $display("FAIL reset_values: tx=%b data=%h busy=%b cnt=%0d full=%b ovf=%b pkt=%0d stall=%0d, want all zero",
               tx, data_o, busy, buf_count, buf_full, overflow, pkt_sent, stall_cycles);
    end
  endtask

  task automatic test_basic_packet();
    flit_t exp;
    do_reset();
    for (int i = 0; i < 4; i++) push(32'hA0 + i);
    checks++;
    if (buf_count !== 5'd4) begin
      fails++; $display("FAIL basic_count: got %0d want 4", buf_count);
    end
    start = 1'b1; dest_xy = make_xy(8'h01, 8'h01); len = 16'd4;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp = (k == 0) ? 32'h0101 : (k == 1) ? 32'd4 : 32'hA0 + 32'(k - 2);
      checks++;
      if (tx !== 1'b1 || data_o !== exp) begin
        fails++; $display("FAIL basic_flit%0d: tx=%b data=%h, want tx=1 data=%h", k, tx, data_o, exp);
      end
      tick();
    end
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL basic_done: tx=%b busy=%b, want tx=0 busy=1", tx, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || pkt_sent !== 32'(STATS) || buf_count !== 5'd0) begin
      fails++; $display("FAIL basic_end: busy=%b pkt=%0d cnt=%0d, want 0 %0d 0", busy, pkt_sent, buf_count, STATS);
    end
  endtask

  task automatic test_credit_stall();
    do_reset();
    for (int i = 0; i < 4; i++) push(32'hA0 + i);
    start = 1'b1; dest_xy = 16'h0101; len = 16'd4;
    tick();
    start = 1'b0;
    tick();
    credit_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (tx !== 1'b1 || data_o !== 32'd4) begin
        fails++; $display("FAIL stall_hold%0d: tx=%b data=%h, want tx=1 data=4", k, tx, data_o);
      end
      tick();
    end
    credit_i = 1'b1;
    checks++;
    if (tx !== 1'b1 || data_o !== 32'd4) begin
      fails++; $display("FAIL stall_release: tx=%b data=%h, want tx=1 data=4", tx, data_o);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tx !== 1'b1 || data_o !== 32'hA0 + 32'(k)) begin
        fails++; $display("FAIL stall_payload%0d: tx=%b data=%h, want tx=1 data=%h", k, tx, data_o, 32'hA0 + k);
      end
      tick();
    end
    tick();
    checks++;
    if (busy !== 1'b0 || stall_cycles !== (STATS ? 32'd3 : 32'd0) || pkt_sent !== 32'(STATS)) begin
      fails++; $display("FAIL stall_stats: busy=%b stall=%0d pkt=%0d, want 0 %0d %0d",
                        busy, stall_cycles, pkt_sent, STATS ? 3 : 0, STATS);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    start = 1'b1; dest_xy = 16'h0203; len = 16'd2;
    tick();
    start = 1'b0;
    checks++;
    if (tx !== 1'b1 || data_o !== 32'h0203) begin
      fails++; $display("FAIL under_hdr: tx=%b data=%h, want 1 0203", tx, data_o);
    end
    tick();
    checks++;
    if (tx !== 1'b1 || data_o !== 32'd2) begin
      fails++; $display("FAIL under_size: tx=%b data=%h, want 1 2", tx, data_o);
    end
    tick();
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
          fails++; $display("FAIL under_gap%0d_%0d: tx=%b busy=%b, want 0 1", f, c, tx, busy);
        end
        tick();
      end
      wr_en = 1'b1; wr_data = 32'hB0 + 32'(f);
      checks++;
      if (tx !== 1'b0) begin
        fails++; $display("FAIL under_nofall%0d: tx=%b, want 0", f, tx);
      end
      tick();
      wr_en = 1'b0;
      checks++;
      if (tx !== 1'b1 || data_o !== 32'hB0 + 32'(f)) begin
        fails++; $display("FAIL under_flit%0d: tx=%b data=%h, want 1 %h", f, tx, data_o, 32'hB0 + f);
      end
      tick();
    end
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL under_done: tx=%b busy=%b, want 0 1", tx, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || buf_count !== 5'd0) begin
      fails++; $display("FAIL under_idle: busy=%b cnt=%0d, want 0 0", busy, buf_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        checks++;
        if (buf_full !== 1'b1 || overflow !== 1'b0 || buf_count !== 5'd16) begin
          fails++; $display("FAIL ovf_at16: full=%b ovf=%b cnt=%0d, want 1 0 16", buf_full, overflow, buf_count);
        end
      end
      push(32'hC0 + 32'(i));
    end
    checks++;
    if (buf_full !== 1'b1 || overflow !== 1'b1 || buf_count !== 5'd16) begin
      fails++; $display("FAIL ovf_after17: full=%b ovf=%b cnt=%0d, want 1 1 16", buf_full, overflow, buf_count);
    end
    start = 1'b1; dest_xy = 16'h0304; len = 16'd16;
    tick();
    start = 1'b0;
    tick(); tick();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (tx !== 1'b1 || data_o !== 32'hC0 + 32'(k)) begin
        fails++; $display("FAIL ovf_payload%0d: tx=%b data=%h, want 1 %h", k, tx, data_o, 32'hC0 + k);
      end
      tick();
    end
    checks++;
    if (tx !== 1'b0 || buf_count !== 5'd0 || overflow !== 1'b1 || buf_full !== 1'b0) begin
      fails++; $display("FAIL ovf_drained: tx=%b cnt=%0d ovf=%b full=%b, want 0 0 1 0", tx, buf_count, overflow, buf_full);
    end
    tick();
  endtask

  task automatic test_len_zero();
    do_reset();
    start = 1'b1; dest_xy = make_xy(8'h0A, 8'h0B); len = 16'd0;
    tick();
    start = 1'b0;
    checks++;
    if (tx !== 1'b1 || data_o !== 32'h0A0B) begin
      fails++; $display("FAIL len0_hdr: tx=%b data=%h, want 1 0a0b", tx, data_o);
    end
    tick();
    checks++;
    if (tx !== 1'b1 || data_o !== 32'd0) begin
      fails++; $display("FAIL len0_size: tx=%b data=%h, want 1 0", tx, data_o);
    end
    tick();
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL len0_done: tx=%b busy=%b, want 0 1", tx, busy);
    end
    tick();
    checks++;
    if (tx !== 1'b0 || busy !== 1'b0 || pkt_sent !== 32'(STATS)) begin
      fails++; $display("FAIL len0_idle: tx=%b busy=%b pkt=%0d, want 0 0 %0d", tx, busy, pkt_sent, STATS);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int i = 0; i < 4; i++) push(32'hE0 + i);
    start = 1'b1; dest_xy = 16'h0505; len = 16'd4;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++;
    if (tx !== 1'b1 || data_o !== 32'hE0) begin
      fails++; $display("FAIL rst_pre: tx=%b data=%h, want 1 e0", tx, data_o);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (tx !== 1'b0 || data_o !== 32'h0 || busy !== 1'b0 || buf_count !== 5'd0 ||
        buf_full !== 1'b0 || overflow !== 1'b0 || pkt_sent !== 32'd0 || stall_cycles !== 32'd0) begin
      fails++;
      $display("FAIL rst_mid_values: tx=%b data=%h busy=%b cnt=%0d full=%b ovf=%b pkt=%0d stall=%0d, want all zero",
               tx, data_o, busy, buf_count, buf_full, overflow, pkt_sent, stall_cycles);
    end
    push(32'hF0); push(32'hF1);
    start = 1'b1; dest_xy = 16'h0707; len = 16'd2;
    tick();
    dest_xy = 16'h0909; len = 16'd5;
    checks++;
    if (tx !== 1'b1 || data_o !== 32'h0707 || busy !== 1'b1) begin
      fails++; $display("FAIL rst_new_hdr: tx=%b data=%h busy=%b, want 1 0707 1", tx, data_o, busy);
    end
    tick();
    start = 1'b0;
    checks++;
    if (tx !== 1'b1 || data_o !== 32'd2) begin
      fails++; $display("FAIL rst_ignored_start: tx=%b data=%h, want 1 2", tx, data_o);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (tx !== 1'b1 || data_o !== 32'hF0 + 32'(k)) begin
        fails++; $display("FAIL rst_new_flit%0d: tx=%b data=%h, want 1 %h", k, tx, data_o, 32'hF0 + k);
      end
      tick();
    end
    tick();
    checks++;
    if (busy !== 1'b0 || tx !== 1'b0 || buf_count !== 5'd0 || pkt_sent !== 32'(STATS)) begin
      fails++; $display("FAIL rst_new_end: busy=%b tx=%b cnt=%0d pkt=%0d, want 0 0 0 %0d",
                        busy, tx, buf_count, pkt_sent, STATS);
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_credit_stall();
    test_underrun();
    test_overflow();
    test_len_zero();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
